label_stats: RTL and testbench

LABEL_STATS -- requirements
Module: label_stats

---
 rtl/label_stats.sv | 158 +++++++++++++++
 tb/tb_label_stats.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/label_stats.sv
// label_stats: scans a 32x32 label map from SRAM, accumulates area and bounding
// box for labels 1..15, then streams one record per present label.
module label_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  output logic        busy_o,
  output logic [9:0]  lab_a_o,
  output logic        lab_rd_o,
  input  logic [7:0]  lab_q_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [3:0]  out_label_o,
  output logic [10:0] out_area_o,
  output logic [4:0]  out_xmin_o,
  output logic [4:0]  out_xmax_o,
  output logic [4:0]  out_ymin_o,
  output logic [4:0]  out_ymax_o,
  output logic        done_o,
  output logic        overflow_o
);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, EMIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [3:0]  idx_q, idx_d;
  logic        rd_vld_q;
  logic [9:0]  rd_addr_q;
  logic        overflow_q;
  logic        clear;
  logic        rec_present;

  logic [10:0] area_q [1:15];
  logic [4:0]  xmin_q [1:15];
  logic [4:0]  xmax_q [1:15];
  logic [4:0]  ymin_q [1:15];
  logic [4:0]  ymax_q [1:15];

  logic [3:0]  lbl;
  logic [4:0]  px_x, px_y;
  logic        px_hit, px_ovf;

  assign lbl    = lab_q_i[3:0];
  assign px_x   = rd_addr_q[4:0];
  assign px_y   = rd_addr_q[9:5];
  assign px_hit = rd_vld_q && (lab_q_i != 8'd0) && (lab_q_i <= 8'd15);
  assign px_ovf = rd_vld_q && (lab_q_i > 8'd15);

  assign rec_present = (state_q == EMIT) && (area_q[idx_q] != 11'd0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          clear   = 1'b1;
          addr_d  = 10'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        addr_d = addr_q + 10'd1;
        if (addr_q == 10'd1023) state_d = DRAIN;
      end
      DRAIN: begin
        idx_d   = 4'd1;
        state_d = EMIT;
      end
      EMIT: begin
        // Empty labels take one cycle; present ones wait for the handshake.
        if (!rec_present || out_ready_i) begin
          if (idx_q == 4'd15) state_d = DONE;
          else                idx_d   = idx_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 10'd0;
      idx_q      <= 4'd0;
      rd_vld_q   <= 1'b0;
      rd_addr_q  <= 10'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      rd_vld_q   <= lab_rd_o;
      rd_addr_q  <= addr_q;
      if (clear)       overflow_q <= 1'b0;
      else if (px_ovf) overflow_q <= 1'b1;
    end
  end

  // NOTE: the stat table is a small flop array, so it takes the async reset like any register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= 15; i++) begin
        area_q[i] <= 11'd0;
        xmin_q[i] <= 5'd31;
        xmax_q[i] <= 5'd0;
        ymin_q[i] <= 5'd31;
        ymax_q[i] <= 5'd0;
      end
    end else if (clear) begin
      for (int i = 1; i <= 15; i++) begin
        area_q[i] <= 11'd0;
        xmin_q[i] <= 5'd31;
        xmax_q[i] <= 5'd0;
        ymin_q[i] <= 5'd31;
        ymax_q[i] <= 5'd0;
      end
    end else if (px_hit) begin
      area_q[lbl] <= area_q[lbl] + 11'd1;
      if (px_x < xmin_q[lbl]) xmin_q[lbl] <= px_x;
      if (px_x > xmax_q[lbl]) xmax_q[lbl] <= px_x;
      if (px_y < ymin_q[lbl]) ymin_q[lbl] <= px_y;
      if (px_y > ymax_q[lbl]) ymax_q[lbl] <= px_y;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign lab_rd_o   = (state_q == SCAN);
  assign lab_a_o    = addr_q;
  assign done_o     = (state_q == DONE);
  assign overflow_o = overflow_q;

  always_comb begin
    out_valid_o = 1'b0;
    out_label_o = 4'd0;
    out_area_o  = 11'd0;
    out_xmin_o  = 5'd0;
    out_xmax_o  = 5'd0;
    out_ymin_o  = 5'd0;
    out_ymax_o  = 5'd0;
    if (rec_present) begin
      out_valid_o = 1'b1;
      out_label_o = idx_q;
      out_area_o  = area_q[idx_q];
      out_xmin_o  = xmin_q[idx_q];
      out_xmax_o  = xmax_q[idx_q];
      out_ymin_o  = ymin_q[idx_q];
      out_ymax_o  = ymax_q[idx_q];
    end
  end

endmodule

// File: tb/tb_label_stats.sv
// Self-checking bench for label_stats: SRAM model, per-label reference computed
// directly from the map, directed and randomized analyses.
module tb_label_stats;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        busy_o;
  logic [9:0]  lab_a_o;
  logic        lab_rd_o;
  logic [7:0]  lab_q_i = 8'd0;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  out_label_o;
  logic [10:0] out_area_o;
  logic [4:0]  out_xmin_o, out_xmax_o, out_ymin_o, out_ymax_o;
  logic        done_o;
  logic        overflow_o;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0]  label;
    logic [10:0] area;
    logic [4:0]  xmin, xmax, ymin, ymax;
  } rec_t;

  logic [7:0] mem [1024];
  rec_t       exp_q [$];
  logic       exp_ovf;

  label_stats dut (
    .clk(clk), .reset(reset), .start_i(start_i), .busy_o(busy_o),
    .lab_a_o(lab_a_o), .lab_rd_o(lab_rd_o), .lab_q_i(lab_q_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_label_o(out_label_o), .out_area_o(out_area_o),
    .out_xmin_o(out_xmin_o), .out_xmax_o(out_xmax_o),
    .out_ymin_o(out_ymin_o), .out_ymax_o(out_ymax_o),
    .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Label SRAM: one-cycle read latency.
  always @(posedge clk) if (lab_rd_o) lab_q_i <= mem[lab_a_o];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input rec_t r);
    return {29'd0, r};
  endfunction

  function automatic rec_t observe();
    rec_t r;
    r.label = out_label_o; r.area = out_area_o;
    r.xmin = out_xmin_o; r.xmax = out_xmax_o;
    r.ymin = out_ymin_o; r.ymax = out_ymax_o;
    return r;
  endfunction

  // Reference: for each label, count its pixels and take min/max coordinates.
  task automatic build_expected();
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < 1024; i++) if (mem[i] > 8'd15) exp_ovf = 1'b1;
    for (int l = 1; l <= 15; l++) begin
      int cnt = 0, x0 = 99, x1 = -1, y0 = 99, y1 = -1;
      for (int y = 0; y < 32; y++)
        for (int x = 0; x < 32; x++)
          if (mem[y*32 + x] == 8'(l)) begin
            cnt++;
            if (x < x0) x0 = x;
            if (x > x1) x1 = x;
            if (y < y0) y0 = y;
            if (y > y1) y1 = y;
          end
      if (cnt > 0) begin
        rec_t r;
        r.label = 4'(l); r.area = 11'(cnt);
        r.xmin = 5'(x0); r.xmax = 5'(x1); r.ymin = 5'(y0); r.ymax = 5'(y1);
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
  endtask

  task automatic random_map(input bit allow_ovf);
    int dens = $urandom_range(1, 60);
    int base = $urandom_range(1, 15);
    int span = $urandom_range(0, 5);
    clear_mem();
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(0, 99) < dens) begin
        int l = base + $urandom_range(0, span);
        mem[i] = 8'((l > 15) ? 15 : l);
      end
      if (allow_ovf && $urandom_range(0, 299) == 0) mem[i] = 8'($urandom_range(16, 255));
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for the first 20 valid cycles.
  task automatic run_analysis(input int mode, input bit mid_start);
    rec_t obs, held;
    bit   have_held = 1'b0, seen_done = 1'b0, rdy;
    int   n = 1, stalls = 0, exp_addr = 0, low_cnt = 0;
    build_expected();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    check("ovf_cleared", 64'(overflow_o), 64'd0);
    while (!seen_done && n < 1400) begin
      if (mid_start) start_i = (n == 100);
      obs = observe();
      check("busy", 64'(busy_o), 64'd1);
      if (lab_rd_o) begin
        check("lab_a", 64'(lab_a_o), 64'(exp_addr));
        exp_addr++;
      end
      if (have_held) check("hold_valid", 64'(out_valid_o), 64'd1);
      if (out_valid_o) begin
        if (have_held) check("stable", pk(obs), pk(held));
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = (low_cnt >= 20);
        endcase
        out_ready_i = rdy;
        if (rdy) begin
          check("rec_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) check("record", pk(obs), pk(exp_q.pop_front()));
          have_held = 1'b0;
        end else begin
          held = obs; have_held = 1'b1; stalls++; low_cnt++;
        end
      end else begin
        check("idle_fields", pk(obs), 64'd0);
        out_ready_i = 1'($urandom_range(0, 1));
      end
      if (done_o) begin
        seen_done = 1'b1;
        check("done_cycle", 64'(n), 64'(1041 + stalls));
        check("overflow", 64'(overflow_o), 64'(exp_ovf));
      end else begin
        @(negedge clk); n++;
      end
    end
    start_i = 1'b0;
    check("done_seen", 64'(seen_done), 64'd1);
    check("rd_count", 64'(exp_addr), 64'd1024);
    check("records_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("done_pulse", 64'(done_o), 64'd0);
    check("busy_end", 64'(busy_o), 64'd0);
    check("ovf_held", 64'(overflow_o), 64'(exp_ovf));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_rd"}, 64'(lab_rd_o), 64'd0);
    check({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_fields"}, pk(observe()), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; out_ready_i = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    check_quiet("rst");
    check("rst_ovf", 64'(overflow_o), 64'd0);
    check("rst_addr", 64'(lab_a_o), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_quiet("idle");

    // All-zero map, with a start pulse mid-scan that must be ignored.
    run_analysis(0, 1'b1);

    // Single pixel label 3 at y=7, x=30.
    clear_mem(); mem[7*32 + 30] = 8'd3;
    run_analysis(0, 1'b0);

    // Full map of label 1: area 1024 without wrap.
    for (int i = 0; i < 1024; i++) mem[i] = 8'd1;
    run_analysis(1, 1'b0);

    // Labels 2 and 9, downstream stalled for 20 cycles on the first record.
    clear_mem();
    for (int y = 3; y < 6; y++) for (int x = 10; x < 14; x++) mem[y*32 + x] = 8'd2;
    mem[31*32 + 0] = 8'd9; mem[20*32 + 31] = 8'd9;
    run_analysis(2, 1'b0);

    // Label 20 plus label 1 sets overflow; the next start clears it.
    clear_mem(); mem[100] = 8'd20; mem[5] = 8'd1; mem[900] = 8'd1;
    run_analysis(1, 1'b0);
    random_map(1'b0);
    run_analysis(1, 1'b0);

    // Reset at scan address 500 aborts; restart on a fresh map.
    clear_mem();
    for (int i = 0; i < 1024; i += 7) mem[i] = 8'd5;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    for (int k = 0; k < 600 && lab_a_o != 10'd500; k++) @(negedge clk);
    check("reached_500", 64'(lab_a_o), 64'd500);
    reset = 1'b1; #1;
    check_quiet("abort");
    check("abort_addr", 64'(lab_a_o), 64'd0);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("no_stale_valid", 64'(out_valid_o), 64'd0);
      check("no_stale_done", 64'(done_o), 64'd0);
    end
    clear_mem(); mem[12*32 + 4] = 8'd7; mem[13*32 + 6] = 8'd7;
    run_analysis(0, 1'b0);

    // Randomized maps and backpressure.
    for (int t = 0; t < 5; t++) begin
      random_map(1'b1);
      run_analysis(1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
